// File: rtl/user_wb_pkg.sv
// -----------------------------------------------------------------------------
// user_wb_pkg
// Shared definitions for the Wishbone mailbox: bus FSM states, register word
// offsets (adr[7:2]), STATUS/CTRL bit positions and a STATUS packing helper.
// No ports.
// -----------------------------------------------------------------------------
package user_wb_pkg;

    // Bus handshake FSM: one idle state, one single-cycle acknowledge state.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } wb_state_t;

    // Register word offsets, compared against adr[7:2].
    localparam logic [5:0] REG_DATA   = 6'h00;
    localparam logic [5:0] REG_STATUS = 6'h01;
    localparam logic [5:0] REG_CTRL   = 6'h02;

    // STATUS fields.
    localparam int STATUS_CNT_LSB = 0;
    localparam int STATUS_CNT_MSB = 4;
    localparam int STATUS_EMPTY   = 5;
    localparam int STATUS_FULL    = 6;
    localparam int STATUS_OVF     = 7;

    // CTRL fields.
    localparam int CTRL_IRQ_EN   = 0;
    localparam int CTRL_THR_LSB  = 1;
    localparam int CTRL_THR_MSB  = 5;

    // Width of the count as seen on the bus and of the irq threshold.
    localparam int CNT_W = 5;
    localparam int THR_W = CTRL_THR_MSB - CTRL_THR_LSB + 1;

    // Assemble the STATUS read word; unused upper bits read as zero.
    function automatic logic [31:0] pack_status(
        input logic [CNT_W-1:0] cnt,
        input logic             empty,
        input logic             full,
        input logic             ovf
    );
        logic [31:0] s;
        s = '0;
        s[STATUS_CNT_MSB:STATUS_CNT_LSB] = cnt;
        s[STATUS_EMPTY]                  = empty;
        s[STATUS_FULL]                   = full;
        s[STATUS_OVF]                    = ovf;
        return s;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with a combinational head output (dout = oldest entry).
// A push while full is accepted only if a pop happens in the same cycle, so a
// full FIFO can stream one word in and one word out per clock.
//
// Ports:
//   clk    in   clock, rising edge
//   rst    in   asynchronous active-high reset (pointers and count only)
//   push   in   write din this cycle (ignored when full without a pop)
//   pop    in   remove the head this cycle (ignored when empty)
//   din    in   WIDTH   write data
//   dout   out  WIDTH   head entry, undefined while empty
//   full   out  count == DEPTH
//   empty  out  count == 0
//   count  out  $clog2(DEPTH)+1   occupancy 0..DEPTH
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_do_push;
    logic w_do_pop;

    assign w_do_pop  = pop & (r_count != '0);
    // A full FIFO still takes a new word when the head leaves in the same cycle.
    assign w_do_push = push & ((r_count != FULL_CNT) | w_do_pop);

    // Pointers are AW bits wide, so incrementing wraps modulo DEPTH for free
    // (DEPTH is a power of two).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; emptiness is tracked by the count,
    // and leaving it out keeps the array mappable to plain RAM/flops.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= din;
    end

    assign dout  = r_mem[r_rd_ptr];
    assign full  = (r_count == FULL_CNT);
    assign empty = (r_count == '0);
    assign count = r_count;

endmodule

// File: rtl/user_wb_mailbox.sv
// -----------------------------------------------------------------------------
// user_wb_mailbox
// Wishbone-classic slave that lets a CPU push 32-bit words into a FIFO which
// drains as a valid/ready stream, with STATUS/CTRL registers and a threshold
// interrupt.
//
// Ports:
//   wb_clk_i   in   clock, rising edge
//   wb_rst_i   in   asynchronous active-high reset
//   wbs_stb_i  in   strobe
//   wbs_cyc_i  in   cycle
//   wbs_we_i   in   write enable
//   wbs_sel_i  in   4   byte selects (only sel[0] matters, for CTRL)
//   wbs_adr_i  in   32  byte address; [31:8] window, [7:2] register
//   wbs_dat_i  in   32  write data
//   wbs_ack_o  out  one-cycle acknowledge, one cycle after the request
//   wbs_dat_o  out  32  read data, valid with ack, zero otherwise
//   m_valid    out  FIFO not empty
//   m_data     out  32  FIFO head
//   m_ready    in   consumer takes the head when m_valid is high
//   irq        out  irq_en & (count >= thresh) & (thresh != 0), registered
// -----------------------------------------------------------------------------
module user_wb_mailbox #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          DEPTH     = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        m_valid,
    output logic [31:0] m_data,
    input  logic        m_ready,
    output logic        irq
);

    import user_wb_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    wb_state_t        r_state;
    logic             r_ack;
    logic [31:0]      r_dat;
    logic             r_ovf;
    logic             r_irq_en;
    logic [THR_W-1:0] r_thresh;
    logic             r_irq;

    logic             w_sel;
    logic [5:0]       w_off;
    logic             w_wr;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [CW-1:0]    w_count;
    logic [CNT_W-1:0] w_count5;
    logic [31:0]      w_rd_data;
    logic             w_unused_bits;

    assign w_sel = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign w_off = wbs_adr_i[7:2];

    // Register side effects fire only in the ACK cycle, once per transfer.
    assign w_wr   = (r_state == ST_ACK) & w_sel & wbs_we_i;
    assign w_push = w_wr & (w_off == REG_DATA);
    assign w_pop  = m_valid & m_ready;

    assign w_count5 = CNT_W'(w_count);

    // Byte lanes and the low address bits carry no meaning for this block.
    assign w_unused_bits = ^{wbs_adr_i[1:0], wbs_sel_i[3:1]};

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .push  (w_push),
        .pop   (w_pop),
        .din   (wbs_dat_i),
        .dout  (m_data),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    assign m_valid = ~w_empty;

    // Read mux; the result is captured on the IDLE->ACK edge.
    always_comb begin
        // NOTE: default first so every path assigns the output and no latch is
        // inferred.
        w_rd_data = '0;
        if (!wbs_we_i) begin
            case (w_off)
                REG_STATUS: w_rd_data = pack_status(w_count5, w_empty, w_full, r_ovf);
                REG_CTRL: begin
                    w_rd_data[CTRL_THR_MSB:CTRL_THR_LSB] = r_thresh;
                    w_rd_data[CTRL_IRQ_EN]               = r_irq_en;
                end
                default: ;
            endcase
        end
    end

    // Bus FSM: ack and read data are registered and live only in ACK.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= ST_IDLE;
            r_ack   <= 1'b0;
            r_dat   <= '0;
        end else begin
            r_ack <= 1'b0;
            r_dat <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_sel) begin
                        r_state <= ST_ACK;
                        r_ack   <= 1'b1;
                        r_dat   <= w_rd_data;
                    end
                end
                ST_ACK:  r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Control/status registers and the interrupt.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_ovf    <= 1'b0;
            r_irq_en <= 1'b0;
            r_thresh <= '0;
            r_irq    <= 1'b0;
        end else begin
            // A push that the FIFO cannot take is lost; remember that it happened.
            if (w_push & w_full & ~w_pop) begin
                r_ovf <= 1'b1;
            end else if (w_wr && (w_off == REG_STATUS) && wbs_dat_i[STATUS_OVF]) begin
                r_ovf <= 1'b0;
            end

            if (w_wr && (w_off == REG_CTRL) && wbs_sel_i[0]) begin
                r_irq_en <= wbs_dat_i[CTRL_IRQ_EN];
                r_thresh <= wbs_dat_i[CTRL_THR_MSB:CTRL_THR_LSB];
            end

            r_irq <= r_irq_en & (w_count5 >= r_thresh) & (r_thresh != '0);
        end
    end

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat;
    assign irq       = r_irq;

endmodule

// File: tb/tb_user_wb_mailbox.sv
// -----------------------------------------------------------------------------
// tb_user_wb_mailbox
// Directed bench for user_wb_mailbox (default BASE_ADDR, DEPTH=8). The bus
// tasks queue the expected read data of every acked transfer; one monitor
// compares wbs_dat_o whenever ack is seen, another compares m_data against the
// queue of expected stream words whenever a word is consumed.
// -----------------------------------------------------------------------------
module tb_user_wb_mailbox;

    localparam logic [31:0] BASE   = 32'h3000_0000;
    localparam logic [31:0] A_DATA = BASE + 32'h00;
    localparam logic [31:0] A_STAT = BASE + 32'h04;
    localparam logic [31:0] A_CTRL = BASE + 32'h08;

    logic        wb_clk_i;
    logic        wb_rst_i;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_ready;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_rd_q[$];
    string       rd_name_q[$];
    logic [31:0] exp_strm_q[$];

    user_wb_mailbox dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .wbs_stb_i (wbs_stb_i),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_ack_o (wbs_ack_o),
        .wbs_dat_o (wbs_dat_o),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_ready   (m_ready),
        .irq       (irq)
    );

    initial begin
        wb_clk_i = 1'b0;
        forever #5 wb_clk_i = ~wb_clk_i;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Bus monitor: every ack must match the oldest queued expectation.
    always @(negedge wb_clk_i) begin
        if (!wb_rst_i && wbs_ack_o) begin
            if (exp_rd_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_ack: ack with nothing queued, adr=0x%08h", wbs_adr_i);
            end else begin
                check(rd_name_q.pop_front(), wbs_dat_o, exp_rd_q.pop_front());
            end
        end
    end

    // Stream monitor: every consumed word must be the oldest expected word.
    always @(negedge wb_clk_i) begin
        if (!wb_rst_i && m_valid && m_ready) begin
            if (exp_strm_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_stream_word: got 0x%08h with nothing queued", m_data);
            end else begin
                check("stream_word", m_data, exp_strm_q.pop_front());
            end
        end
    end

    // One Wishbone classic transfer. If ready_in_ack is set, m_ready is held
    // high for exactly the ACK cycle.
    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input bit exp_ack,
                           input logic [31:0] exp_rd, input string name,
                           input bit ready_in_ack);
        int lat;
        bit got;
        @(posedge wb_clk_i);
        #1;
        wbs_stb_i = 1'b1;
        wbs_cyc_i = 1'b1;
        wbs_we_i  = we;
        wbs_adr_i = adr;
        wbs_dat_i = dat;
        wbs_sel_i = sel;
        if (exp_ack) begin
            exp_rd_q.push_back(exp_rd);
            rd_name_q.push_back(name);
        end
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge wb_clk_i);
            lat++;
            if (wbs_ack_o) begin
                got = 1'b1;
                break;
            end
            if (ready_in_ack && i == 0) begin
                @(posedge wb_clk_i);
                #1 m_ready = 1'b1;
            end
        end
        if (exp_ack) begin
            check({name, "_ack_seen"}, 32'(got), 32'd1);
            if (got) check({name, "_ack_latency"}, 32'(lat), 32'd2);
        end else begin
            check({name, "_no_ack"}, 32'(got), 32'd0);
        end
        @(posedge wb_clk_i);
        #1;
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_we_i  = 1'b0;
        wbs_adr_i = '0;
        wbs_dat_i = '0;
        wbs_sel_i = '0;
        if (ready_in_ack) m_ready = 1'b0;
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, input string name);
        wb_xfer(1'b1, adr, dat, sel, 1'b1, 32'h0, name, 1'b0);
    endtask

    task automatic wb_read(input logic [31:0] adr, input logic [31:0] exp, input string name);
        wb_xfer(1'b0, adr, 32'h0, 4'hF, 1'b1, exp, name, 1'b0);
    endtask

    task automatic push_word(input logic [31:0] dat, input bit accepted);
        if (accepted) exp_strm_q.push_back(dat);
        wb_write(A_DATA, dat, 4'hF, "push");
    endtask

    // Let the consumer take everything; bounded wait for the FIFO to empty.
    task automatic drain(input string name);
        m_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge wb_clk_i);
            #1;
            if (!m_valid) break;
        end
        m_ready = 1'b0;
        check({name, "_empty"}, 32'(m_valid), 32'd0);
        check({name, "_all_words_seen"}, exp_strm_q.size(), 32'd0);
    endtask

    initial begin
        wb_rst_i  = 1'b1;
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_we_i  = 1'b0;
        wbs_sel_i = '0;
        wbs_adr_i = '0;
        wbs_dat_i = '0;
        m_ready   = 1'b0;

        // Reset state.
        repeat (3) @(posedge wb_clk_i);
        #1;
        check("reset_ack", 32'(wbs_ack_o), 32'd0);
        check("reset_dat", wbs_dat_o, 32'h0);
        check("reset_m_valid", 32'(m_valid), 32'd0);
        check("reset_irq", 32'(irq), 32'd0);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        wb_read(A_STAT, 32'h0000_0020, "status_after_reset");

        // Single push: head visible the cycle after the ack, count=1, not empty.
        push_word(32'h1234_5678, 1'b1);
        check("first_m_valid", 32'(m_valid), 32'd1);
        check("first_m_data", m_data, 32'h1234_5678);
        wb_read(A_STAT, 32'h0000_0001, "status_one_word");
        drain("drain_single");
        wb_read(A_STAT, 32'h0000_0020, "status_drained");

        // Nine pushes into eight entries: last one lost, overflow sticky.
        for (int i = 0; i < 9; i++) push_word(32'hA000_0000 + 32'(i), i < 8);
        wb_read(A_STAT, 32'h0000_00C8, "status_overflow");
        wb_write(A_STAT, 32'h0000_0080, 4'hF, "overflow_clear");
        wb_read(A_STAT, 32'h0000_0048, "status_ovf_cleared");

        // Push and pop in the same cycle while full: both accepted.
        exp_strm_q.push_back(32'hBEEF_0001);
        wb_xfer(1'b1, A_DATA, 32'hBEEF_0001, 4'hF, 1'b1, 32'h0, "push_pop_full", 1'b1);
        wb_read(A_STAT, 32'h0000_0048, "status_push_pop_full");
        drain("drain_full");
        wb_read(A_STAT, 32'h0000_0020, "status_drained2");

        // CTRL: enable, thresh=3; sel[0]=0 write is ignored.
        wb_write(A_CTRL, 32'h0000_0007, 4'hF, "ctrl_write");
        wb_read(A_CTRL, 32'h0000_0007, "ctrl_readback");
        wb_write(A_CTRL, 32'h0000_0000, 4'hE, "ctrl_write_sel0_low");
        wb_read(A_CTRL, 32'h0000_0007, "ctrl_unchanged");

        // irq rises the cycle after the third push lands, falls after a pop.
        push_word(32'hC000_0000, 1'b1);
        push_word(32'hC000_0001, 1'b1);
        push_word(32'hC000_0002, 1'b1);
        check("irq_low_at_third_push", 32'(irq), 32'd0);
        @(posedge wb_clk_i);
        #1;
        check("irq_rise", 32'(irq), 32'd1);
        m_ready = 1'b1;
        @(posedge wb_clk_i);
        #1;
        m_ready = 1'b0;
        check("irq_still_high_at_pop", 32'(irq), 32'd1);
        @(posedge wb_clk_i);
        #1;
        check("irq_fall", 32'(irq), 32'd0);

        // Address decode.
        wb_xfer(1'b0, BASE + 32'h100, 32'h0, 4'hF, 1'b0, 32'h0, "outside_window", 1'b0);
        wb_read(BASE + 32'h0C, 32'h0, "unmapped_read");
        wb_write(BASE + 32'h0C, 32'hFFFF_FFFF, 4'hF, "unmapped_write");
        wb_read(A_STAT, 32'h0000_0002, "status_unmapped_write");
        wb_read(A_DATA, 32'h0, "data_read_zero");

        // Fill to four entries, then reset in the middle of an ACK.
        push_word(32'hC000_0003, 1'b1);
        push_word(32'hC000_0004, 1'b1);
        wb_read(A_STAT, 32'h0000_0004, "status_four");
        @(posedge wb_clk_i);
        #1;
        wbs_stb_i = 1'b1;
        wbs_cyc_i = 1'b1;
        wbs_we_i  = 1'b1;
        wbs_adr_i = A_DATA;
        wbs_dat_i = 32'hDEAD_0000;
        wbs_sel_i = 4'hF;
        exp_rd_q.push_back(32'h0);
        rd_name_q.push_back("push_under_reset");
        begin
            bit got;
            got = 1'b0;
            for (int i = 0; i < 4; i++) begin
                @(negedge wb_clk_i);
                if (wbs_ack_o) begin
                    got = 1'b1;
                    break;
                end
            end
            check("reset_mid_ack_seen", 32'(got), 32'd1);
        end
        #1 wb_rst_i = 1'b1;
        #1;
        check("reset_mid_ack", 32'(wbs_ack_o), 32'd0);
        check("reset_mid_m_valid", 32'(m_valid), 32'd0);
        check("reset_mid_dat", wbs_dat_o, 32'h0);
        check("reset_mid_irq", 32'(irq), 32'd0);
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_we_i  = 1'b0;
        wbs_adr_i = '0;
        wbs_dat_i = '0;
        wbs_sel_i = '0;
        exp_strm_q.delete();
        @(posedge wb_clk_i);
        @(posedge wb_clk_i);
        #2 wb_rst_i = 1'b0;
        wb_read(A_STAT, 32'h0000_0020, "status_after_mid_reset");
        wb_read(A_CTRL, 32'h0000_0000, "ctrl_after_mid_reset");
        check("m_valid_after_mid_reset", 32'(m_valid), 32'd0);
        check("irq_after_mid_reset", 32'(irq), 32'd0);
        check("bus_scoreboard_empty", exp_rd_q.size(), 32'd0);

        repeat (2) @(posedge wb_clk_i);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
